// File: rtl/mux81_rr.sv
// Round-robin 8-to-1 collector: arbitrates eight valid/ready channels onto one
// registered output stream tagged with the source channel number.
module mux81_rr #(
    parameter int unsigned WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         in_valid,
    input  logic [8*WIDTH-1:0] in_data,
    output logic [7:0]         in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [2:0]         out_sel,
    input  logic               out_ready,
    output logic [15:0]        xfer_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [2:0]         sel_q, sel_d;
    logic [2:0]         last_q, last_d;
    logic [15:0]        cnt_q, cnt_d;

    logic               load_en;
    logic               found;
    logic [2:0]         gnt_idx;

    // Search starts one past the last winner; the last winner itself is visited last.
    always_comb begin
        found   = 1'b0;
        gnt_idx = last_q;
        for (int unsigned k = 1; k <= 8; k++) begin
            logic [2:0] idx;
            idx = last_q + 3'(k);
            if (!found && in_valid[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    assign load_en  = (state_q == EMPTY) || out_ready;
    assign in_ready = (rst_n && load_en && found) ? (8'd1 << gnt_idx) : '0;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        if (state_q == FULL && out_ready) begin
            cnt_d = cnt_q + 16'd1;
        end
        if (load_en) begin
            if (found) begin
                state_d = FULL;
                data_d  = in_data[gnt_idx*WIDTH +: WIDTH];
                sel_d   = gnt_idx;
                last_d  = gnt_idx;
            end else begin
                state_d = EMPTY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            sel_q   <= '0;
            last_q  <= 3'd7;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_sel   = sel_q;
    assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_mux81_rr.sv
// Scoreboard bench for mux81_rr: stimulus pushes expected {sel,data} words,
// a negedge monitor pops and compares on every output transfer.
module tb_mux81_rr;
    localparam int unsigned W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [7:0]     in_valid;
    logic [8*W-1:0] in_data;
    logic [7:0]     in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [2:0]     out_sel;
    logic           out_ready;
    logic [15:0]    xfer_cnt;

    mux81_rr #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [10:0]   exp_q[$];
    int            exp_ch[8];
    int            got_ch[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int ch, input logic [7:0] d);
        exp_q.push_back({3'(ch), d});
        exp_ch[ch]++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int ch, input logic [7:0] d);
        in_data[ch*W +: W] = d;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Monitor: each negedge with out_valid & out_ready precedes exactly one transfer.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", {21'd0, out_sel, out_data}, 32'h7FF);
            end else begin
                logic [10:0] e;
                e = exp_q.pop_front();
                check("out_word", {21'd0, out_sel, out_data}, {21'd0, e});
                got_ch[out_sel]++;
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            exp_ch[i] = 0;
            got_ch[i] = 0;
        end
        rst_n     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        #1;
        check("init_out_valid", 32'(out_valid), 0);
        check("init_out_sel",   32'(out_sel), 0);
        check("init_xfer",      32'(xfer_cnt), 0);
        check("init_in_ready",  32'(in_ready), 0);
        tick();
        tick();
        rst_n = 1'b1;

        // Single channel
        in_valid = 8'h08;
        set_data(3, 8'h01);
        out_ready = 1'b1;
        @(negedge clk);
        check("single_in_ready", 32'(in_ready), 32'h08);
        push(3, 8'h01);
        tick();
        in_valid = '0;
        @(negedge clk);
        check("single_out_valid", 32'(out_valid), 1);
        check("single_in_ready_off", 32'(in_ready), 0);
        check("single_xfer_pre", 32'(xfer_cnt), 0);
        tick();
        @(negedge clk);
        check("single_xfer_post", 32'(xfer_cnt), 1);
        check("single_empty", 32'(out_valid), 0);
        tick();

        // Full contention from reset
        do_reset();
        for (int i = 0; i < 8; i++) set_data(i, 8'(8'h10 + i));
        in_valid = 8'hFF;
        for (int k = 0; k < 10; k++) begin
            logic [7:0] oh;
            oh = 8'd1 << (k % 8);
            @(negedge clk);
            check("rr_in_ready", 32'(in_ready), 32'(oh));
            push(k % 8, 8'(8'h10 + (k % 8)));
            tick();
        end
        in_valid = '0;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("rr_xfer", 32'(xfer_cnt), 10);
        check("rr_empty", 32'(out_valid), 0);
        tick();

        // Backpressure (last = 1 here)
        in_valid = 8'h20;
        set_data(5, 8'h55);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_grant5", 32'(in_ready), 32'h20);
        push(5, 8'h55);
        tick();
        in_valid = 8'h40;
        set_data(6, 8'h66);
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 0);
            check("bp_out_valid", 32'(out_valid), 1);
            check("bp_out_sel", 32'(out_sel), 5);
            check("bp_out_data", 32'(out_data), 32'h55);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_grant6", 32'(in_ready), 32'h40);
        push(6, 8'h66);
        tick();
        in_valid = '0;
        @(negedge clk);
        check("bp_out_sel6", 32'(out_sel), 6);
        tick();
        @(negedge clk);
        check("bp_xfer", 32'(xfer_cnt), 12);
        check("bp_empty", 32'(out_valid), 0);
        tick();

        // Pointer skip: park last at 2, then ch1 and ch7 compete
        do_reset();
        in_valid = 8'h04;
        set_data(2, 8'h22);
        @(negedge clk);
        check("skip_grant2", 32'(in_ready), 32'h04);
        push(2, 8'h22);
        tick();
        in_valid = 8'h82;
        set_data(1, 8'h71);
        set_data(7, 8'h17);
        @(negedge clk);
        check("skip_grant7", 32'(in_ready), 32'h80);
        push(7, 8'h17);
        tick();
        in_valid = 8'h02;
        @(negedge clk);
        check("skip_grant1", 32'(in_ready), 32'h02);
        push(1, 8'h71);
        tick();
        in_valid = '0;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("skip_xfer", 32'(xfer_cnt), 3);
        tick();

        // Reset mid-stream: held ch4 word is discarded, ch2 keeps waiting
        out_ready = 1'b0;
        in_valid  = 8'h10;
        set_data(4, 8'h44);
        @(negedge clk);
        check("mid_grant4", 32'(in_ready), 32'h10);
        tick();
        in_valid = 8'h04;
        set_data(2, 8'h2A);
        @(negedge clk);
        check("mid_held_valid", 32'(out_valid), 1);
        check("mid_held_sel", 32'(out_sel), 4);
        check("mid_in_ready", 32'(in_ready), 0);
        #1 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("async_out_valid", 32'(out_valid), 0);
        check("async_out_data", 32'(out_data), 0);
        check("async_out_sel", 32'(out_sel), 0);
        check("async_xfer", 32'(xfer_cnt), 0);
        check("async_in_ready", 32'(in_ready), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        in_valid  = 8'h44;
        set_data(6, 8'h6B);
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_grant2", 32'(in_ready), 32'h04);
        push(2, 8'h2A);
        tick();
        in_valid = 8'h40;
        @(negedge clk);
        check("post_rst_grant6", 32'(in_ready), 32'h40);
        push(6, 8'h6B);
        tick();
        in_valid = '0;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("post_rst_xfer", 32'(xfer_cnt), 2);
        tick();

        // Counter wrap: 65537 transfers at full rate
        do_reset();
        for (int i = 0; i < 8; i++) set_data(i, 8'(8'h80 + i));
        in_valid  = 8'hFF;
        out_ready = 1'b1;
        for (int k = 0; k < 65537; k++) begin
            push(k % 8, 8'(8'h80 + (k % 8)));
            tick();
        end
        in_valid = '0;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("wrap_xfer", 32'(xfer_cnt), 1);
        check("wrap_empty", 32'(out_valid), 0);
        check("wrap_queue_drained", 32'(exp_q.size()), 0);
        for (int i = 0; i < 8; i++) begin
            check("per_channel_count", 32'(got_ch[i]), 32'(exp_ch[i]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
